// File: rtl/board_program_loader_if.sv
// Board pin bundle: dip switches and push keys in, led and seven-segment status out.
// Latency: none, wires only.
// Backpressure: none, the board drives and observes the pins freely.
interface board_program_loader_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] dip;
    logic [4:0]        key;
    logic [DATA_W-1:0] led;
    logic [12:0]       sevenseg;

    // Board side drives the switches and keys, and watches the displays.
    modport master (output dip, output key, input led, input sevenseg);
    // Loader side samples the switches and keys, and drives the displays.
    modport slave  (input dip, input key, output led, output sevenseg);
endinterface

// File: rtl/board_program_loader.sv
// Key-driven program loader: debounced keys fill and step a DEPTH-word instruction memory into ir.
// Latency: a key action lands DEBOUNCE_CYCLES+3 edges after the first edge that sees the key high; a fetch updates ir one cycle after it starts.
// Backpressure: none; key pulses that arrive during the one-cycle FETCH state are dropped, except the clears.
module board_program_loader #(
    parameter int DATA_W          = 16,
    parameter int ADDR_W          = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    board_program_loader_if.slave  io
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        FETCH = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [4:0]         sync1, sync2, deb, pulse;
    logic [CNT_W-1:0]   cnt [5];
    logic [ADDR_W-1:0]  eom, pc, sel;
    logic [DATA_W-1:0]  ir, rdata;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic               wr_en, rd_en;

    // Key conditioning: synchronise, require DEBOUNCE_CYCLES stable cycles, and pulse on each accepted press.
    // The pulse is raised together with the debounced level, so the FSM acts on the following edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            pulse <= '0;
            for (int i = 0; i < 5; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= io.key;
            sync2 <= sync1;
            pulse <= '0;
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    deb[i]   <= sync2[i];
                    pulse[i] <= sync2[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Mode/fetch state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and strobes: a mode toggle beats a write or step arriving in the same cycle.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        unique case (state)
            LOAD: begin
                if (pulse[4]) begin
                    state_nxt = RUN;
                end else if (pulse[0]) begin
                    wr_en = 1'b1;
                end
            end
            RUN: begin
                if (pulse[4]) begin
                    state_nxt = LOAD;
                end else if (pulse[1]) begin
                    rd_en     = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    // Instruction memory: not reset; writes and reads are mode-exclusive so they never collide.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[eom] <= io.dip;
        end
        if (rd_en && !rst) begin
            rdata <= mem[pc];
        end
    end

    // Load address: clear wins over the post-write increment; wraps at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            eom <= '0;
        end else if (pulse[2]) begin
            eom <= '0;
        end else if (wr_en) begin
            eom <= eom + ADDR_W'(1);
        end
    end

    // Program counter: clear wins over the fetch increment; wraps at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
        end else if (pulse[3]) begin
            pc <= '0;
        end else if (state == FETCH) begin
            pc <= pc + ADDR_W'(1);
        end
    end

    // Instruction register loads the read data in the FETCH cycle, even if pc is being cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir <= '0;
        end else if (state == FETCH) begin
            ir <= rdata;
        end
    end

    // Board outputs, derived only from registers.
    always_comb begin
        sel         = (state == LOAD) ? eom : pc;
        io.led      = ir;
        io.sevenseg = {3'b000, (state == FETCH), (state != LOAD), 8'(sel)};
    end

endmodule

// File: tb/tb_board_program_loader.sv
module tb_board_program_loader;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int DB = 4;

    typedef struct packed {
        logic [4:0]  key;
        logic [15:0] dip;
        logic [12:0] ss;
        logic [15:0] led;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    vec_t vecs [17];

    always #5 clk = ~clk;

    board_program_loader_if #(.DATA_W(DW)) bus ();

    board_program_loader #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clean press: hold well past the debounce window, then release and let it settle.
    task automatic press(input logic [4:0] k, input logic [15:0] d);
        bus.dip = d;
        bus.key = k;
        tick(10);
        bus.key = '0;
        tick(10);
    endtask

    // One step with cycle-by-cycle observation of busy and led timing.
    task automatic watch_step(input string name, input logic [15:0] exp_led);
        int          busy_n;
        int          busy_idx;
        int          led_idx;
        logic [15:0] led0;
        busy_n   = 0;
        busy_idx = -1;
        led_idx  = -1;
        led0     = bus.led;
        bus.key  = 5'b00010;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.sevenseg[9]) begin
                busy_n++;
                if (busy_idx < 0) busy_idx = i;
            end
            if (led_idx < 0 && bus.led !== led0) led_idx = i;
        end
        bus.key = '0;
        tick(10);
        check({name, " busy cycle"}, 32'(busy_idx), 32'd7);
        check({name, " busy length"}, 32'(busy_n), 32'd1);
        check({name, " led cycle"}, 32'(led_idx), 32'd8);
        check({name, " led"}, {16'h0, bus.led}, {16'h0, exp_led});
    endtask

    initial begin
        int          first;
        int          busy_seen;
        logic [7:0]  eom0;

        // Load/run/clear walk: {key, dip, expected sevenseg, expected led}
        vecs[0]  = '{5'b00001, 16'hA001, 13'h001, 16'h0000};
        vecs[1]  = '{5'b00001, 16'hB002, 13'h002, 16'h0000};
        vecs[2]  = '{5'b00001, 16'hC003, 13'h003, 16'h0000};
        vecs[3]  = '{5'b10000, 16'h0000, 13'h100, 16'h0000};
        vecs[4]  = '{5'b00010, 16'h0000, 13'h101, 16'hA001};
        vecs[5]  = '{5'b00010, 16'h0000, 13'h102, 16'hB002};
        vecs[6]  = '{5'b00010, 16'h0000, 13'h103, 16'hC003};
        vecs[7]  = '{5'b01000, 16'h0000, 13'h100, 16'hC003};
        vecs[8]  = '{5'b00010, 16'h0000, 13'h101, 16'hA001};
        vecs[9]  = '{5'b10000, 16'h0000, 13'h003, 16'hA001};
        vecs[10] = '{5'b00100, 16'h0000, 13'h000, 16'hA001};
        vecs[11] = '{5'b00010, 16'h0000, 13'h000, 16'hA001};
        vecs[12] = '{5'b00001, 16'hD004, 13'h001, 16'hA001};
        vecs[13] = '{5'b10000, 16'h0000, 13'h101, 16'hA001};
        vecs[14] = '{5'b00001, 16'h1234, 13'h101, 16'hA001};
        vecs[15] = '{5'b01000, 16'h0000, 13'h100, 16'hA001};
        vecs[16] = '{5'b00010, 16'h0000, 13'h101, 16'hD004};

        // Reset with random pin activity
        rst     = 1'b1;
        bus.key = 5'($urandom);
        bus.dip = 16'($urandom);
        tick(2);
        check("reset led", {16'h0, bus.led}, 32'h0);
        check("reset sevenseg", {19'h0, bus.sevenseg}, 32'h0);
        bus.key = '0;
        rst     = 1'b0;
        tick(10);
        check("post-reset sevenseg", {19'h0, bus.sevenseg}, 32'h0);

        for (int i = 0; i < 17; i++) begin
            press(vecs[i].key, vecs[i].dip);
            check($sformatf("vec%0d sevenseg", i), {19'h0, bus.sevenseg}, {19'h0, vecs[i].ss});
            check($sformatf("vec%0d led", i), {16'h0, bus.led}, {16'h0, vecs[i].led});
        end

        // Debounce: short bounces are rejected, a long hold gives exactly one write on edge 7
        press(5'b10000, 16'h0);
        eom0 = bus.sevenseg[7:0];
        check("debounce start eom", {24'h0, eom0}, 32'h1);
        bus.dip = 16'h5555;
        for (int r = 0; r < 5; r++) begin
            bus.key = 5'b00001;
            tick(3);
            bus.key = '0;
            tick(3);
        end
        tick(6);
        check("bounce eom unchanged", {19'h0, bus.sevenseg}, 32'h001);
        first   = -1;
        bus.key = 5'b00001;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (first < 0 && bus.sevenseg[7:0] !== eom0) first = i;
        end
        bus.key = '0;
        tick(10);
        check("hold increment cycle", 32'(first), 32'd7);
        check("hold single increment", {19'h0, bus.sevenseg}, 32'h002);

        // Wrap-around of eom and pc
        press(5'b00100, 16'h0);
        for (int i = 0; i < 16; i++) press(5'b00001, 16'h1000 + 16'(i));
        check("eom wrap", {19'h0, bus.sevenseg}, 32'h000);
        press(5'b10000, 16'h0);
        press(5'b01000, 16'h0);
        for (int i = 0; i < 16; i++) press(5'b00010, 16'h0);
        check("pc wrap sevenseg", {19'h0, bus.sevenseg}, 32'h100);
        check("pc wrap led", {16'h0, bus.led}, 32'h100F);
        press(5'b00010, 16'h0);
        check("step 17 sevenseg", {19'h0, bus.sevenseg}, 32'h101);
        check("step 17 led", {16'h0, bus.led}, 32'h1000);

        // Clear coinciding with write: eom ends at 0 but mem[5] is written
        press(5'b10000, 16'h0);
        for (int i = 0; i < 5; i++) press(5'b00001, 16'h2000 + 16'(i));
        check("eom five", {19'h0, bus.sevenseg}, 32'h005);
        press(5'b00101, 16'hBEEF);
        check("clear beats write", {19'h0, bus.sevenseg}, 32'h000);
        press(5'b10000, 16'h0);
        press(5'b01000, 16'h0);
        for (int i = 0; i < 5; i++) press(5'b00010, 16'h0);
        check("mem4 led", {16'h0, bus.led}, 32'h2004);
        press(5'b00010, 16'h0);
        check("mem5 written", {16'h0, bus.led}, 32'hBEEF);
        check("pc six", {19'h0, bus.sevenseg}, 32'h106);
        watch_step("timed step", 16'h1006);

        // Mode toggle beats a simultaneous step
        busy_seen = 0;
        bus.key   = 5'b10010;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.sevenseg[9]) busy_seen++;
        end
        bus.key = '0;
        tick(10);
        check("toggle+step no busy", 32'(busy_seen), 32'd0);
        check("toggle+step to load", {19'h0, bus.sevenseg}, 32'h000);
        check("toggle+step led kept", {16'h0, bus.led}, 32'h1006);
        press(5'b10000, 16'h0);
        check("pc kept at 7", {19'h0, bus.sevenseg}, 32'h107);

        // Reset during FETCH aborts the fetch
        bus.key = 5'b00010;
        tick(7);
        check("busy before reset", {31'h0, bus.sevenseg[9]}, 32'h1);
        rst = 1'b1;
        tick(1);
        check("mid-fetch reset led", {16'h0, bus.led}, 32'h0);
        check("mid-fetch reset sevenseg", {19'h0, bus.sevenseg}, 32'h0);
        bus.key = '0;
        tick(2);
        rst = 1'b0;
        tick(10);
        check("after reset sevenseg", {19'h0, bus.sevenseg}, 32'h0);
        check("after reset led", {16'h0, bus.led}, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/board_program_loader.md
Name: board_program_loader

Overview:
- Parametrised successor to the board-level front-end that uses dip switches and push keys to fill and step an instruction memory.
- Debounces and edge-detects all keys, owns the load-address counter (eom) and program counter (pc), and contains a DEPTH-word instruction memory.
- Fetches instructions into an instruction register (ir) and drives led and sevenseg for board inspection.
- Sits between the board I/O pins and the future processor datapath. ir and pc become the datapath fetch interface.

Parameters:
- DATA_W, 16: instruction/dip width; width of memory words, ir and led.
- ADDR_W, 8: address width; DEPTH = 2^ADDR_W. Legal range 1..8.
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before a key change is accepted. Use 16 for simulation, ~500000 on the board.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- dip  input  DATA_W  data word written to memory in LOAD mode.
- key  input  5  raw asynchronous push keys:
  - key[0]: write+advance
  - key[1]: step
  - key[2]: clear eom
  - key[3]: clear pc
  - key[4]: mode toggle
- led  output  DATA_W  current ir.
- sevenseg  output  13  status word:
  - [7:0] = selected address, zero-extended: eom in LOAD, pc in RUN.
  - [8] = mode (0=LOAD, 1=RUN).
  - [9] = fetch busy.
  - [12:10] = 0.

Behaviour:
- Clock/reset: one clock. Reset is synchronous and active-high.
- Reset values: eom=0, pc=0, ir=0, mode=LOAD, busy=0, all debounced keys=0, all pulses=0. Therefore led=0 and sevenseg=0.
- Memory contents are not reset.
- rst asserted mid-fetch aborts the fetch; ir stays 0.
- Key conditioning, per key:
  - 2-flop synchroniser, then debounce counter.
  - The debounced level changes only after the synchronised level has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce restarts the count.
  - A rising edge of the debounced level gives a 1-cycle pulse.
  - Fixed latency L = DEBOUNCE_CYCLES+3 cycles from the first clk edge sampling key high to the pulse.
  - Release produces no pulse. A key held produces exactly one pulse.
- FSM states: LOAD, RUN, FETCH.
- LOAD:
  - key[0] pulse: mem[eom] <= dip, then eom <= eom+1 in the same cycle. eom wraps from DEPTH-1 to 0.
  - key[1] pulse is ignored.
  - key[4] pulse -> RUN.
- RUN:
  - key[1] pulse: synchronous read of mem[pc], busy=1 -> FETCH.
  - key[0] pulse is ignored.
  - key[4] pulse -> LOAD.
- FETCH (exactly 1 cycle):
  - ir <= read data, pc <= pc+1. pc wraps from DEPTH-1 to 0.
  - busy=0 -> RUN.
  - Pulses arriving in FETCH are dropped. This is guaranteed harmless because L exceeds 1.
- Clear keys:
  - key[2] pulse sets eom <= 0 in any state.
  - key[3] pulse sets pc <= 0 in any state.
  - A clear coinciding with an increment wins: the result is 0.
  - key[3] in FETCH still loads ir; pc ends at 0.
- Simultaneous key[4] with key[0] or key[1] in the same cycle: mode toggle takes priority; the write/step is dropped.
- Read-during-write cannot occur, because writes and fetches are mode-exclusive.
- Outputs are registered or derived directly from registers; there are no combinational paths from key or dip.

Test Plan:
All scenarios use DATA_W=16, ADDR_W=4, DEBOUNCE_CYCLES=4, so L=7.

- Reset: hold rst 2 cycles with random keys/dip -> led=0x0000, sevenseg=0x000. Only then release rst.
- Load and read-back:
  - In LOAD, write dip=0xA001, 0xB002, 0xC003 via three clean key[0] presses -> sevenseg[7:0]=3.
  - Press key[4] -> sevenseg[8]=1, [7:0]=0.
  - Three key[1] presses -> led becomes 0xA001, 0xB002, 0xC003 in turn, each 1 cycle after its fetch starts; busy visible for 1 cycle; final pc=3.
- Debounce: pulse key[0] high 3 cycles then low, repeat 5 times -> eom unchanged.
  - Then hold key[0] 20 cycles -> eom increments by exactly 1, on cycle 7 after the key rises.
- Wrap-around:
  - 16 writes -> eom=0.
  - In RUN, 17 steps -> pc=1, led=mem[0].
- Simultaneous events:
  - key[2] and key[0] pressed the same cycle with eom=5 -> eom=0 and mem[5] is written.
  - key[4] and key[1] in the same cycle -> mode toggles and no fetch occurs.
- Reset mid-operation: assert rst during FETCH -> next cycle ir=0, pc=0, mode=LOAD, busy=0.
